// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter: word accepted on load&ready, sent MSB first, 1 bit/clk;
// first bit one cycle after load, done NDATA+1 cycles after load; stall pauses SHIFT without losing bits.
module piso_shift_tx #(
  parameter int NDATA = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NDATA-1:0] din,
  input  logic             load,
  input  logic             stall,
  output logic             ready,
  output logic             sout,
  output logic             sena_n,
  output logic             done
);

  localparam int NDATA_LOG = $clog2(NDATA);
  localparam logic [NDATA_LOG-1:0] CNT_LAST = NDATA_LOG'(NDATA - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [NDATA-1:0]     shreg_q, shreg_d;
  logic [NDATA_LOG-1:0] cnt_q, cnt_d;
  logic                 sout_q, sout_d;
  logic                 sena_n_q, sena_n_d;
  logic                 done_q, done_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
      sout_q   <= 1'b0;
      sena_n_q <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      sout_q   <= sout_d;
      sena_n_q <= sena_n_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    sout_d   = sout_q;
    sena_n_d = sena_n_q;
    done_d   = done_q;
    case (state_q)
      IDLE: begin
        sena_n_d = 1'b1;
        done_d   = 1'b0;
        if (load) begin
          shreg_d = din;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        done_d = 1'b0;
        if (stall) begin
          sena_n_d = 1'b1;
        end else begin
          sout_d   = shreg_q[NDATA-1];
          sena_n_d = 1'b0;
          shreg_d  = {shreg_q[NDATA-2:0], 1'b0};
          // Counter parks at the last index so it never wraps
          if (cnt_q == CNT_LAST) begin
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + NDATA_LOG'(1);
          end
        end
      end
      DONE: begin
        sena_n_d = 1'b1;
        done_d   = 1'b1;
        sout_d   = 1'b0;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ready  = (state_q == IDLE);
  assign sout   = sout_q;
  assign sena_n = sena_n_q;
  assign done   = done_q;

endmodule
